// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter
//   Shares one I2C EEPROM master between two clients. Each client asks for a
//   single byte read or write. The arbiter picks a winner round-robin and
//   launches the master with the winner's captured fields. It waits for the
//   master to finish, with a timeout abort, and then reports the result back
//   to the winning client only.
//
// Ports
//   clk_in, reset_n          clock, asynchronous active-low reset
//   cX_req/rw/addr/wdata     client X request (held until cX_done)
//   cX_done/err/rdata        client X completion pulse, error flag, read data
//   m_start/rw/addr/wdata    launch pulse and captured fields to the master
//   m_abort                  one-cycle pulse forcing the master to STOP
//   m_done/nack/rdata        completion pulse and result from the master
//   grant                    one-hot current owner (00 = none)
module eeprom_arbiter #(
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              c0_req,
  input  logic              c0_rw,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [7:0]        c0_wdata,
  output logic              c0_done,
  output logic              c0_err,
  output logic [7:0]        c0_rdata,
  input  logic              c1_req,
  input  logic              c1_rw,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [7:0]        c1_wdata,
  output logic              c1_done,
  output logic              c1_err,
  output logic [7:0]        c1_rdata,
  output logic              m_start,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wdata,
  output logic              m_abort,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;      // 1 = client 1 was granted last
  logic [15:0]         cnt_q, cnt_d;
  logic                m_rw_q, m_rw_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [7:0]          m_wdata_q, m_wdata_d;
  logic                c0_err_q, c0_err_d, c1_err_q, c1_err_d;
  logic [7:0]          c0_rdata_q, c0_rdata_d, c1_rdata_q, c1_rdata_d;
  logic                abort;
  logic                fin;
  logic                fin_err;
  logic [7:0]          fin_rdata;
  logic                pick1;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      cnt_q      <= 16'd0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= 8'd0;
      c0_err_q   <= 1'b0;
      c1_err_q   <= 1'b0;
      c0_rdata_q <= 8'd0;
      c1_rdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m_rw_q     <= m_rw_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      c0_err_q   <= c0_err_d;
      c1_err_q   <= c1_err_d;
      c0_rdata_q <= c0_rdata_d;
      c1_rdata_q <= c1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m_rw_d     = m_rw_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    c0_err_d   = c0_err_q;
    c1_err_d   = c1_err_q;
    c0_rdata_d = c0_rdata_q;
    c1_rdata_d = c1_rdata_q;
    abort      = 1'b0;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = 8'd0;
    // Client 1 wins if it is alone, or on a tie when client 0 went last.
    pick1      = c1_req && (!c0_req || !last_q);

    case (state_q)
      S_IDLE: begin
        if (c0_req || c1_req) begin
          grant_d   = pick1 ? 2'b10 : 2'b01;
          m_rw_d    = pick1 ? c1_rw    : c0_rw;
          m_addr_d  = pick1 ? c1_addr  : c0_addr;
          m_wdata_d = pick1 ? c1_wdata : c0_wdata;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the timeout cycle takes priority over the abort.
        if (m_done) begin
          fin       = 1'b1;
          fin_err   = m_nack;
          fin_rdata = m_rdata;
          state_d   = S_RESP;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          abort     = 1'b1;
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = 8'd0;   // no data came back, so report zero
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Results are written into the owner's registers so they are already
    // valid during the RESP cycle, when done pulses.
    if (fin && grant_q[0]) begin
      c0_err_d   = fin_err;
      c0_rdata_d = fin_rdata;
    end
    if (fin && grant_q[1]) begin
      c1_err_d   = fin_err;
      c1_rdata_d = fin_rdata;
    end
  end

  assign m_start  = (state_q == S_ISSUE);
  assign m_abort  = abort;
  assign m_rw     = m_rw_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign grant    = grant_q;
  assign c0_done  = (state_q == S_RESP) && grant_q[0];
  assign c1_done  = (state_q == S_RESP) && grant_q[1];
  assign c0_err   = c0_err_q;
  assign c1_err   = c1_err_q;
  assign c0_rdata = c0_rdata_q;
  assign c1_rdata = c1_rdata_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter
//   Directed stimulus for eeprom_arbiter with TIMEOUT = 10. Each issued
//   request pushes its expected master launch, the master's scripted
//   response and the expected client completion into queues. Monitor and
//   master-model processes consume these queues independently of the
//   stimulus.
module tb_eeprom_arbiter;
  localparam int          AW = 8;
  localparam logic [15:0] TO = 16'd10;

  typedef struct {logic rw; logic [7:0] addr; logic [7:0] wdata;} start_t;
  typedef struct {int cl; logic err; logic [7:0] rdata;} done_t;
  typedef struct {int lat; logic [7:0] rdata; logic nack;} resp_t;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b0;
  logic          c0_req = 1'b0, c0_rw = 1'b0, c1_req = 1'b0, c1_rw = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [7:0]    c0_wdata = 8'd0, c1_wdata = 8'd0;
  logic          c0_done, c0_err, c1_done, c1_err;
  logic [7:0]    c0_rdata, c1_rdata;
  logic          m_start, m_rw, m_abort;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  logic          m_done = 1'b0, m_nack = 1'b0;
  logic [7:0]    m_rdata = 8'd0;
  logic [1:0]    grant;

  start_t exp_start[$];
  done_t  exp_done[$];
  resp_t  resp_q[$];

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     start_cyc = 0;
  int     abort_cnt = 0;
  start_t last_st;

  always #5 clk_in = ~clk_in;

  eeprom_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .c0_req(c0_req), .c0_rw(c0_rw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_done(c0_done), .c0_err(c0_err), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_rw(c1_rw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_done(c1_done), .c1_err(c1_err), .c1_rdata(c1_rdata),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .grant(grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Queue one client transaction. lat < 0 means the master never answers.
  task automatic issue(input int cl, input logic rw, input logic [7:0] addr,
                       input logic [7:0] wd, input int lat, input logic [7:0] rd,
                       input logic nack, input bit want_done);
    bit to;
    to = (lat < 0) || (lat > int'(TO) - 1);
    exp_start.push_back('{rw, addr, wd});
    resp_q.push_back('{lat, rd, nack});
    if (want_done) exp_done.push_back('{cl, to ? 1'b1 : nack, to ? 8'd0 : rd});
    if (cl == 0) begin
      c0_rw = rw; c0_addr = addr; c0_wdata = wd; c0_req = 1'b1;
    end else begin
      c1_rw = rw; c1_addr = addr; c1_wdata = wd; c1_req = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (exp_done.size() == 0 && exp_start.size() == 0) return;
    end
    fail_now(name);
    exp_done.delete();
    exp_start.delete();
    resp_q.delete();
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (grant == g) return;
    end
    fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_m_start"}, m_start, 0);
    chk({tag, "_m_abort"}, m_abort, 0);
    chk({tag, "_done"}, {c0_done, c1_done}, 0);
    chk({tag, "_err"}, {c0_err, c1_err}, 0);
    chk({tag, "_c0_rdata"}, c0_rdata, 0);
    chk({tag, "_c1_rdata"}, c1_rdata, 0);
    chk({tag, "_m_fields"}, {m_rw, m_addr, m_wdata}, 0);
  endtask

  task automatic check_done(input int cl);
    done_t d;
    if (exp_done.size() == 0) begin
      fail_now($sformatf("unexpected_c%0d_done", cl));
      return;
    end
    d = exp_done.pop_front();
    chk("done_client", cl, d.cl);
    chk($sformatf("c%0d_err", cl), (cl == 0) ? c0_err : c1_err, d.err);
    chk($sformatf("c%0d_rdata", cl), (cl == 0) ? c0_rdata : c1_rdata, d.rdata);
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Monitor: master launches, field stability, aborts and client completions.
  initial begin : monitor
    start_t s;
    forever begin
      @(negedge clk_in);
      if (m_start) begin
        if (exp_start.size() == 0) fail_now("unexpected_m_start");
        else begin
          s = exp_start.pop_front();
          chk("m_rw", m_rw, s.rw);
          chk("m_addr", m_addr, s.addr);
          chk("m_wdata", m_wdata, s.wdata);
          last_st = s;
          start_cyc = cyc;
        end
      end
      if (m_done) begin
        chk("m_rw_hold", m_rw, last_st.rw);
        chk("m_addr_hold", m_addr, last_st.addr);
        chk("m_wdata_hold", m_wdata, last_st.wdata);
      end
      if (m_abort) begin
        abort_cnt++;
        chk("abort_offset", cyc - start_cyc, int'(TO));
      end
      if (c0_done) check_done(0);
      if (c1_done) check_done(1);
    end
  end

  // Master model: answers each launch with the next scripted response.
  initial begin : master
    resp_t r;
    forever begin
      @(negedge clk_in);
      if (m_start && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.lat >= 0) begin
          step();
          repeat (r.lat) step();
          m_rdata = r.rdata; m_nack = r.nack; m_done = 1'b1;
          step();
          m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'd0;
        end
      end
    end
  end

  // Clients release their request once they see their completion.
  initial forever begin
    @(negedge clk_in);
    if (c0_done) c0_req = 1'b0;
    if (c1_done) c1_req = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    @(negedge clk_in);
    check_reset_outputs("rst");
    step();
    reset_n = 1'b1;
    step();

    // tie right after reset: client 0 first, then client 1
    issue(0, 1'b0, 8'h20, 8'h11, 1, 8'h77, 1'b0, 1'b1);
    issue(1, 1'b1, 8'h21, 8'h00, 2, 8'h5A, 1'b0, 1'b1);
    wait_idle("tie1");

    // single read
    step();
    issue(0, 1'b1, 8'h12, 8'h00, 3, 8'hA5, 1'b0, 1'b1);
    wait_idle("single_read");

    // tie after client 0 was served: client 1 first
    step();
    issue(1, 1'b1, 8'h31, 8'h00, 0, 8'h3E, 1'b0, 1'b1);
    issue(0, 1'b0, 8'h32, 8'h64, 2, 8'h10, 1'b0, 1'b1);
    wait_idle("tie2");

    // NACKed write from client 1; client 0 outputs must not move
    step();
    issue(1, 1'b0, 8'h40, 8'h3C, 2, 8'h99, 1'b1, 1'b1);
    wait_idle("nack_write");
    chk("c0_rdata_hold", c0_rdata, 8'h10);
    chk("c0_err_hold", c0_err, 1'b0);

    // client fields change after grant; the launched transaction is unaffected
    step();
    issue(0, 1'b1, 8'h33, 8'h00, 4, 8'hC3, 1'b0, 1'b1);
    wait_grant(2'b01, "grant_c0");
    c0_addr = 8'hFF; c0_wdata = 8'hEE; c0_rw = 1'b0;
    wait_idle("field_change");

    // master never answers: abort and error
    step();
    issue(0, 1'b0, 8'h55, 8'hAA, -1, 8'h00, 1'b0, 1'b1);
    wait_idle("timeout");
    chk("abort_count_timeout", abort_cnt, 1);

    // completion on the timeout cycle wins over the abort
    step();
    issue(1, 1'b1, 8'h56, 8'h00, 9, 8'h6E, 1'b0, 1'b1);
    wait_idle("boundary_ok");
    step();
    issue(0, 1'b1, 8'h57, 8'h00, 9, 8'h81, 1'b1, 1'b1);
    wait_idle("boundary_nack");
    chk("abort_count_boundary", abort_cnt, 1);
    chk("c1_rdata_hold", c1_rdata, 8'h6E);

    // reset while waiting on the master: everything clears, no done, no abort
    step();
    issue(1, 1'b1, 8'h60, 8'h00, -1, 8'h00, 1'b0, 1'b0);
    wait_grant(2'b10, "grant_c1");
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    c1_req = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (15) step();
    chk("abort_count_reset", abort_cnt, 1);

    // tie again after reset: client 0 wins first once more
    issue(0, 1'b1, 8'h70, 8'h00, 1, 8'h0F, 1'b0, 1'b1);
    issue(1, 1'b0, 8'h71, 8'hF0, 1, 8'hF1, 1'b0, 1'b1);
    wait_idle("tie3");
    chk("resp_queue_empty", resp_q.size(), 0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eeprom_arbiter.md
EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: width of client and master byte-address fields.
REQ-002 Parameter TIMEOUT, default 16'd50000: maximum clk_in cycles spent in WAIT before abort; legal range 2..65535.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cX_req (X=0,1)  input  1  client X requests one EEPROM byte transaction; held high until cX_done.
REQ-006 cX_rw  input  1  1 = read, 0 = write.
REQ-007 cX_addr  input  ADDR_W  byte address.
REQ-008 cX_wdata  input  8  write data.
REQ-009 cX_done  output  1  one-cycle pulse: client X transaction finished.
REQ-010 cX_err  output  1  valid with cX_done; 1 = NACK or timeout.
REQ-011 cX_rdata  output  8  read data; valid with cX_done, held until next cX_done.
REQ-012 m_start  output  1  one-cycle pulse launching a transaction on the shared I2C master.
REQ-013 m_rw, m_addr, m_wdata  output  1/ADDR_W/8  captured fields of the granted client; stable from m_start until return to IDLE.
REQ-014 m_abort  output  1  one-cycle pulse forcing the master to STOP and release the bus.
REQ-015 m_done  input  1  one-cycle pulse from the master: transaction complete.
REQ-016 m_nack  input  1  valid with m_done; slave NACKed.
REQ-017 m_rdata  input  8  valid with m_done.
REQ-018 grant  output  2  one-hot owner (01 = client 0, 10 = client 1, 00 = none).

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-020 IDLE: if any cX_req is high, select a winner, capture its rw/addr/wdata into m_* registers, set grant, go to ISSUE; else stay.
REQ-021 Round-robin: on simultaneous requests, the client not granted most recently wins; a lone requester always wins.
REQ-022 ISSUE: m_start = 1 for exactly this one cycle; clear timeout counter; go to WAIT.
REQ-023 WAIT: m_done = 1 -> latch m_rdata and m_nack, go to RESP; else increment the 16-bit counter.
REQ-024 WAIT: counter reaching TIMEOUT-1 with m_done low -> m_abort pulses for one cycle, err latched as 1, go to RESP.
REQ-025 m_done and timeout in the same cycle: m_done wins; no m_abort; err = m_nack.
REQ-026 m_done in IDLE, ISSUE or RESP is ignored.
REQ-027 RESP: granted client's cX_done = 1 for one cycle, cX_err per REQ-023/024, cX_rdata updated (reads and writes alike); record winner as last-granted; grant -> 00; go to IDLE.
REQ-028 Latency: req first seen high at edge N -> m_start high during cycle N+1; m_done at edge M -> cX_done high during cycle M+1.
REQ-029 Minimum turnaround: one IDLE cycle between RESP and the next ISSUE.
REQ-030 Client dropping cX_req before grant: no transaction. After grant: transaction completes and cX_done still pulses.
REQ-031 Changes on client fields after grant do not affect the in-flight transaction.
REQ-032 Non-granted client's done/err/rdata outputs remain unchanged.

Reset
REQ-033 reset_n low: state IDLE, grant = 00, m_start = m_abort = 0, cX_done = cX_err = 0, cX_rdata = 0, m_rw/m_addr/m_wdata = 0, counter = 0, last-granted = client 1 (client 0 wins first tie).
REQ-034 Reset mid-transaction: no cX_done and no m_abort issued; the master is reset separately by the same reset_n.
REQ-035 First edge after reset_n deasserts behaves as IDLE.

Verification
REQ-036 Single read: c0 req, rw=1, addr=0x12; master m_done with m_rdata=0xA5, m_nack=0 -> one m_start with m_addr=0x12, c0_done pulse, c0_err=0, c0_rdata=0xA5.
REQ-037 Tie after reset: c0, c1 req same cycle -> c0 served first, then c1; repeated tie -> c1 then c0 alternate.
REQ-038 NACK write: c1 write addr=0x40 wdata=0x3C, m_done with m_nack=1 -> c1_done, c1_err=1, m_wdata=0x3C during WAIT.
REQ-039 Timeout: TIMEOUT=10, master never responds -> m_abort pulse exactly 9 cycles after the first WAIT cycle, c0_done with c0_err=1.
REQ-040 Boundary: m_done on the timeout cycle -> no m_abort, err=m_nack; reset_n low during WAIT -> all outputs reset values, no done pulse.
